mulmod_pipe: RTL and testbench

- Pipelined Barrett modular multiplier: result = (A * B) mod q.
- Sits in the NTT/FFT butterfly datapath directly upstream of the modular adder/subtractor. It produces the twiddle product W*B that AddMod/SubMod consume.
- Fully pipelined: one operation per cycle, valid/ready handshake, sideband tag carried alongside each operation.

---
 rtl/mulmod_pipe.sv | 147 ++++++++++++++
 tb/tb_mulmod_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mulmod_pipe.sv
// Pipelined Barrett modular multiplier: result = (a_in * b_in) mod modular, 4 stages, valid/ready.
// Optional MULMOD_RANGE_CHK_EN adds a sticky range_err flag for operands >= modular.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mulmod_pipe #(
  parameter int unsigned DW    = `DATA_WIDTH,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  input  logic [DW-1:0]    modular,
  input  logic [DW:0]      mu_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    result,
`ifdef MULMOD_RANGE_CHK_EN
  output logic             range_err,
`endif
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned RW = DW + 2;
  localparam int unsigned MW = DW + 1;

  logic             stall;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, out_valid_q, out_valid_d;
  logic [PW-1:0]    p1_q, p1_d;
  logic [DW-1:0]    q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
  logic [MW-1:0]    mu1_q, mu1_d, qhat2_q, qhat2_d;
  logic [RW-1:0]    p2_q, p2_d, r3_q, r3_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d, tag_out_q, tag_out_d;
  logic [DW-1:0]    result_q, result_d;
  logic [PW+1:0]    qprod;
  logic [RW-1:0]    d1, r1, d2, r2;

  // Every stage holds while the output slot is full and not taken.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    out_valid_d = out_valid_q;
    p1_d        = p1_q;
    q1_d        = q1_q;
    mu1_d       = mu1_q;
    tag1_d      = tag1_q;
    qhat2_d     = qhat2_q;
    p2_d        = p2_q;
    q2_d        = q2_q;
    tag2_d      = tag2_q;
    r3_d        = r3_q;
    q3_d        = q3_q;
    tag3_d      = tag3_q;
    result_d    = result_q;
    tag_out_d   = tag_out_q;

    qprod = (PW+2)'(p1_q >> (DW-1)) * (PW+2)'(mu1_q);
    // Final correction: two conditional subtracts, sign bit of the RW-bit difference decides.
    d1 = r3_q - RW'(q3_q);
    r1 = d1[RW-1] ? r3_q : d1;
    d2 = r1 - RW'(q3_q);
    r2 = d2[RW-1] ? r1 : d2;

    if (!stall) begin
      v1_d        = in_valid;
      p1_d        = PW'(a_in) * PW'(b_in);
      q1_d        = modular;
      mu1_d       = mu_in;
      tag1_d      = tag_in;

      v2_d        = v1_q;
      qhat2_d     = MW'(qprod >> (DW+1));
      p2_d        = RW'(p1_q);
      q2_d        = q1_q;
      tag2_d      = tag1_q;

      v3_d        = v2_q;
      r3_d        = p2_q - RW'(qhat2_q) * RW'(q2_q);
      q3_d        = q2_q;
      tag3_d      = tag2_q;

      out_valid_d = v3_q;
      result_d    = DW'(r2);
      tag_out_d   = tag3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; out_valid_q <= 1'b0;
      p1_q <= '0; q1_q <= '0; mu1_q <= '0; tag1_q <= '0;
      qhat2_q <= '0; p2_q <= '0; q2_q <= '0; tag2_q <= '0;
      r3_q <= '0; q3_q <= '0; tag3_q <= '0;
      result_q <= '0; tag_out_q <= '0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; out_valid_q <= out_valid_d;
      p1_q <= p1_d; q1_q <= q1_d; mu1_q <= mu1_d; tag1_q <= tag1_d;
      qhat2_q <= qhat2_d; p2_q <= p2_d; q2_q <= q2_d; tag2_q <= tag2_d;
      r3_q <= r3_d; q3_q <= q3_d; tag3_q <= tag3_d;
      result_q <= result_d; tag_out_q <= tag_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

`ifdef MULMOD_RANGE_CHK_EN
  // Out-of-range flag rides with its op; sticky once that op is handed off.
  logic e1_q, e1_d, e2_q, e2_d, e3_q, e3_d, e4_q, e4_d, range_err_q, range_err_d;

  always_comb begin
    e1_d = e1_q;
    e2_d = e2_q;
    e3_d = e3_q;
    e4_d = e4_q;
    range_err_d = range_err_q | (out_valid_q & out_ready & e4_q);
    if (!stall) begin
      e1_d = (a_in >= modular) | (b_in >= modular);
      e2_d = e1_q;
      e3_d = e2_q;
      e4_d = e3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_q <= 1'b0; e2_q <= 1'b0; e3_q <= 1'b0; e4_q <= 1'b0; range_err_q <= 1'b0;
    end else begin
      e1_q <= e1_d; e2_q <= e2_d; e3_q <= e3_d; e4_q <= e4_d; range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_mulmod_pipe.sv
// Directed self-checking bench for mulmod_pipe at DW=16, q=40961, mu=104855.
// Define MULMOD_RANGE_CHK_EN on both files to exercise range_err.
module tb_mulmod_pipe;
  localparam int unsigned DW    = 16;
  localparam int unsigned TAG_W = 8;
  localparam logic [DW-1:0] Q   = 16'd40961;
  localparam logic [DW:0]   MU  = 17'd104855;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    a_in, b_in;
  logic [DW-1:0]    modular;
  logic [DW:0]      mu_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    result;
  logic [TAG_W-1:0] tag_out;
`ifdef MULMOD_RANGE_CHK_EN
  logic             range_err;
`endif

  int checks   = 0;
  int failures = 0;

  mulmod_pipe #(.DW(DW), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .modular   (modular),
    .mu_in     (mu_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef MULMOD_RANGE_CHK_EN
    .range_err (range_err),
`endif
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TAG_W-1:0] t);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    tag_in   = t;
  endtask

  // Backpressure stimulus and expected results (a*1000 mod q, all below q).
  logic [DW-1:0]    bp_a   [6] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
  logic [DW-1:0]    bp_exp [6] = '{16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd5000, 16'd6000};

  initial begin
    int sent, got, stall_cnt;
    bit stall_seen;
    logic [DW-1:0]    held_res;
    logic [TAG_W-1:0] held_tag;

    rst = 1'b1; out_ready = 1'b1; modular = Q; mu_in = MU;
    drive(1'b0, '0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_tag_out", 32'(tag_out), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef MULMOD_RANGE_CHK_EN
    check("rst_range_err", 32'(range_err), 0);
`endif

    // Basic products, back to back
    drive(1'b1, 16'd3, 16'd5, 8'h01);     tick();
    drive(1'b1, 16'd20000, 16'd3, 8'h02); tick();
    drive(1'b1, 16'd40960, 16'd2, 8'h03); tick();
    drive(1'b0, '0, '0, '0);
    check("basic_pre_valid", 32'(out_valid), 0);
    tick();
    check("basic1_valid", 32'(out_valid), 1);
    check("basic1_res", 32'(result), 15);
    check("basic1_tag", 32'(tag_out), 32'h01);
    tick();
    check("basic2_res", 32'(result), 19039);
    check("basic2_tag", 32'(tag_out), 32'h02);
    tick();
    check("basic3_res", 32'(result), 40959);
    check("basic3_tag", 32'(tag_out), 32'h03);
    tick();
    check("basic_drain", 32'(out_valid), 0);

    // Corner operands
    drive(1'b1, 16'd40960, 16'd40960, 8'h11); tick();
    drive(1'b1, 16'd0, 16'd12345, 8'h12);     tick();
    drive(1'b1, 16'd1, 16'd40960, 8'h13);     tick();
    drive(1'b0, '0, '0, '0);                  tick();
    check("corner_qm1_sq", 32'(result), 1);
    tick();
    check("corner_zero", 32'(result), 0);
    tick();
    check("corner_one", 32'(result), 40960);
    check("corner_tag", 32'(tag_out), 32'h13);
    tick();

    // Backpressure: 3-cycle out_ready drop once the first result appears
    sent = 0; got = 0; stall_cnt = 0; stall_seen = 1'b0;
    held_res = '0; held_tag = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (out_valid && !stall_seen) begin
        stall_seen = 1'b1;
        stall_cnt  = 3;
        held_res   = result;
        held_tag   = tag_out;
      end
      out_ready = (stall_cnt == 0);
      if (sent < 6) drive(1'b1, bp_a[sent], 16'd1000, 8'(8'h20 + sent));
      else          drive(1'b0, '0, '0, '0);
      #1;
      if (stall_cnt > 0) begin
        check("bp_in_ready_low", 32'(in_ready), 0);
        check("bp_res_hold", 32'(result), 32'(held_res));
        check("bp_tag_hold", 32'(tag_out), 32'(held_tag));
        stall_cnt--;
      end
      if (out_valid && out_ready) begin
        check("bp_res", 32'(result), 32'(bp_exp[got]));
        check("bp_tag", 32'(tag_out), 32'h20 + 32'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    check("bp_all_received", 32'(got), 6);
    check("bp_stall_seen", 32'(stall_seen), 1);
    check("bp_no_dup", 32'(out_valid), 0);
    tick();

    // Bubbles: 1,0,1,0,1 in gives 1,0,1,0,1 out four cycles later
    drive(1'b1, 16'd2, 16'd3, 8'h31);     tick();
    drive(1'b0, '0, '0, '0);              tick();
    drive(1'b1, 16'd4, 16'd5, 8'h32);     tick();
    drive(1'b0, '0, '0, '0);              tick();
    drive(1'b1, 16'd100, 16'd409, 8'h33);
    check("bub_v0", 32'(out_valid), 1);
    check("bub_r0", 32'(result), 6);
    tick();
    drive(1'b0, '0, '0, '0);
    check("bub_v1", 32'(out_valid), 0);
    tick();
    check("bub_v2", 32'(out_valid), 1);
    check("bub_r2", 32'(result), 20);
    tick();
    check("bub_v3", 32'(out_valid), 0);
    tick();
    check("bub_v4", 32'(out_valid), 1);
    check("bub_r4", 32'(result), 40900);
    check("bub_t4", 32'(tag_out), 32'h33);
    tick();

    // Reset with three ops in flight
    drive(1'b1, 16'd11, 16'd11, 8'h41); tick();
    drive(1'b1, 16'd12, 16'd12, 8'h42); tick();
    drive(1'b1, 16'd13, 16'd13, 8'h43); tick();
    drive(1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_result", 32'(result), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    drive(1'b1, 16'd7, 16'd9, 8'h44); tick();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_stale", 32'(out_valid), 0);
      tick();
    end
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_res", 32'(result), 63);
    check("post_rst_tag", 32'(tag_out), 32'h44);
    tick();

    // Out-of-range operand: flag (if built) sticky, and the pipe keeps flowing
    drive(1'b1, 16'd40961, 16'd1, 8'h51); tick();
    drive(1'b0, '0, '0, '0);
    tick(); tick(); tick();
    check("range_valid", 32'(out_valid), 1);
    check("range_tag", 32'(tag_out), 32'h51);
`ifdef MULMOD_RANGE_CHK_EN
    check("range_err_before", 32'(range_err), 0);
`endif
    tick();
`ifdef MULMOD_RANGE_CHK_EN
    check("range_err_set", 32'(range_err), 1);
`endif
    drive(1'b1, 16'd7, 16'd9, 8'h52); tick();
    drive(1'b0, '0, '0, '0);
    tick(); tick(); tick();
    check("range_nolock_valid", 32'(out_valid), 1);
    check("range_nolock_res", 32'(result), 63);
    tick();
`ifdef MULMOD_RANGE_CHK_EN
    check("range_err_sticky", 32'(range_err), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
